axi_sram_rd_slave: RTL and testbench
====================================

AXI_SRAM_RD_SLAVE -- requirements
Module: axi_sram_rd_slave

Interface
REQ-001 Parameter MEM_AW, default 14, byte-address bits decoded; memory is 2^(MEM_AW-2) 32-bit words.
REQ-002 Parameter FIFO_DEPTH, default 2, output buffer entries; fixed at 2 for this release.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  AXI read-address fields.
REQ-007 arvalid in 1, arready out 1  AR handshake.
REQ-008 rid/rdata/rresp/rlast  out  4/32/2/1  AXI read-data fields.
REQ-009 rvalid out 1, rready in 1  R handshake.
REQ-010 sram_en  out  1  synchronous SRAM read strobe.
REQ-011 sram_addr  out  MEM_AW-2  word address.
REQ-012 sram_rdata  in  32  SRAM data, valid the cycle after sram_en.

Function
REQ-013 States: IDLE, BURST. arready SHALL be 1 only in IDLE; an AR handshake in IDLE latches all AR fields and moves to BURST.
REQ-014 BURST SHALL return exactly arlen+1 beats, with rid equal to the latched arid on every beat.
REQ-015 rlast SHALL be 1 only on beat arlen. The R handshake on that beat returns the FSM to IDLE, so arready is 1 the next cycle.
REQ-016 Address step is 1<<arsize. Sequencing:
  - FIXED (0): same address every beat.
  - INCR (1): address += step.
  - WRAP (2): address wraps within an aligned window of (arlen+1)*step bytes.
REQ-017 sram_addr SHALL be address[MEM_AW-1:2]. Upper address bits are ignored (aliasing). rdata is the full aligned word for every arsize.
REQ-018 Illegal request, defined as any of arburst=3, arsize>2, or WRAP with arlen not in {1,3,7,15}:
  - arlen+1 beats are still returned.
  - rresp=2'b10 (SLVERR), rdata=0.
  - sram_en=0 for the whole burst.
REQ-019 Legal request: rresp=2'b00 on every beat.
REQ-020 Read issue: sram_en=1 in a cycle iff in BURST, beats issued < arlen+1, and (buffered + in-flight − pop_this_cycle) < 2. pop = rvalid&&rready; sram_en may depend combinationally on rready.
REQ-021 At most one read SHALL be in flight. sram_rdata is written into the output buffer at the end of the cycle after issue.
REQ-022 Latency: AR handshake in cycle T gives sram_en in T+1 and first rvalid in T+3. With rready held 1, one beat per cycle follows with no bubbles.
REQ-023 rvalid=1 iff the buffer is non-empty. Payload SHALL be stable while rvalid&&!rready. No beat is lost or duplicated under any rready pattern.
REQ-024 Simultaneous push and pop on a full (2-entry) buffer SHALL be correct.
REQ-025 arvalid in BURST SHALL be ignored. The request stays pending on the bus and is accepted after return to IDLE.

Reset
REQ-026 While rst=1:
  - state=IDLE, buffer and in-flight count cleared.
  - arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, sram_en=0, sram_addr=0.
REQ-027 Reset mid-burst SHALL discard the burst with no further R beats. arready=1 the first cycle after rst deasserts.

Structure
REQ-028 Shared package axi_pkg SHALL hold the burst encodings FIXED/INCR/WRAP, the response codes OKAY/SLVERR, and the state enum.
REQ-029 The 2-entry output buffer SHALL be a sub-module axi_rd_fifo, carrying {rdata,rresp,rlast}. The SRAM is external.

Verification
REQ-030 INCR burst: araddr=0x100, arlen=3, arsize=2, rready=1.
  - sram_addr goes 0x40..0x43.
  - 4 OKAY beats; rlast on the 4th.
  - First rvalid 3 cycles after AR.
REQ-031 WRAP burst: araddr=0x38, arlen=3, arsize=2.
  - sram_addr sequence 0x0E,0x0F,0x0C,0x0D.
REQ-032 Backpressure: INCR arlen=7 with rready toggling 1,0,0,1,...
  - All 8 words returned in order.
  - Data held stable while stalled.
  - sram_en never causes more than 2 entries buffered plus in-flight.
REQ-033 Illegal requests: arburst=3, arlen=2.
  - 3 beats, rresp=SLVERR, rdata=0, sram_en never asserted.
  - Repeat with WRAP arlen=2: same result.
REQ-034 rst asserted on beat 2 of a 16-beat burst.
  - rvalid=0 immediately after.
  - arready=1 the cycle after release.
  - A new arlen=0 read returns a single beat with rlast=1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM read slave: burst encodings,
// response codes, FSM state type and request legality check.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

    // A request is answered with SLVERR beats (and no SRAM access) when the
    // burst type is reserved, the beat is wider than the 32-bit bus, or a
    // WRAP burst has a length AXI does not allow.
    function automatic logic is_illegal_req(input logic [1:0] burst,
                                            input logic [2:0] size,
                                            input logic [7:0] len);
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) ||
                         (len == 8'd7) || (len == 8'd15));
        return (burst == 2'd3) || (size > 3'd2) ||
               ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// Small circular output buffer holding read beats {rdata, rresp, rlast}
// until the master accepts them. A push and a pop in the same cycle are
// allowed even when the buffer is full.
module axi_rd_fifo #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              vld,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];
    assign vld      = (count != '0);

    // Beat storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-only slave in front of a synchronous single-port SRAM.
// One burst at a time: AR is accepted in IDLE, then BURST issues one SRAM
// read per beat (at most one in flight) into a small output buffer that
// drives the R channel. Illegal requests return SLVERR beats without
// touching the SRAM.
module axi_sram_rd_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW     = 14,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              sram_en,
    output logic [MEM_AW-3:0] sram_addr,
    input  logic [31:0]       sram_rdata
);

    localparam int BUF_W = 35;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_t         state;
    logic              arready_q;
    logic [8:0]        issued_q;

    logic [3:0]        id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              illegal_q;

    logic              ar_hs;
    logic              pop;
    logic              issue_p0;
    logic              vld_p1;
    logic              last_p1;
    logic              err_p1;

    logic [BUF_W-1:0]  push_data;
    logic [BUF_W-1:0]  buf_data;
    logic              buf_vld;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    occupancy;
    logic [31:0]       buf_rdata;
    logic [1:0]        buf_resp;
    logic              buf_last;

    // Address of the following beat for FIXED / INCR / WRAP sequencing.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                   input logic [1:0]  burst,
                                                   input logic [2:0]  size,
                                                   input logic [7:0]  len);
        logic [31:0] step;
        logic [31:0] incr;
        logic [31:0] wrap_mask;
        logic [31:0] result;
        step      = 32'd1 << size;
        incr      = addr + step;
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: result = addr;
            BURST_WRAP:  result = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     result = incr;
        endcase
        return result;
    endfunction

    // Outputs are forced quiet while reset is held, including the cycle in
    // which reset is first sampled.
    assign arready = arready_q && !rst;
    assign ar_hs   = arvalid && arready;
    assign rvalid  = buf_vld && !rst;
    assign pop     = rvalid && rready;

    assign {buf_rdata, buf_resp, buf_last} = buf_data;
    assign rid       = rst ? '0 : id_q;
    assign rdata     = rst ? '0 : buf_rdata;
    assign rresp     = rst ? '0 : buf_resp;
    assign rlast     = rst ? '0 : buf_last;
    assign sram_addr = rst ? '0 : addr_q[MEM_AW-1:2];

    // Issue stage p0: issue only while buffered + in-flight beats, after this
    // cycle's pop, leave room for the new one. Error beats go through the same
    // pipeline so latency and ordering are identical, but never strobe SRAM.
    assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, vld_p1}
                     - {{CNT_W{1'b0}}, pop};
    assign issue_p0  = !rst && (state == ST_BURST)
                     && (issued_q <= {1'b0, len_q})
                     && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign sram_en   = issue_p0 && !illegal_q;

    // Control FSM: AR acceptance, beats-issued count, return to IDLE on last pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            arready_q <= 1'b1;
            issued_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        state     <= ST_BURST;
                        arready_q <= 1'b0;
                        issued_q  <= '0;
                    end
                end
                ST_BURST: begin
                    if (issue_p0) begin
                        issued_q <= issued_q + 9'd1;
                    end
                    if (pop && buf_last) begin
                        state     <= ST_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    arready_q <= 1'b1;
                end
            endcase
        end
    end

    // Request fields captured on AR; the beat address advances on each issue.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            id_q      <= arid;
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            illegal_q <= is_illegal_req(arburst, arsize, arlen);
        end else if (issue_p0) begin
            addr_q <= next_beat_addr(addr_q, burst_q, size_q, len_q);
        end
    end

    // Stage p1: one read in flight; SRAM data arrives during this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue_p0;
        end
    end

    // Per-beat attributes travelling with the in-flight read.
    always_ff @(posedge clk) begin
        if (issue_p0) begin
            last_p1 <= (issued_q[7:0] == len_q);
            err_p1  <= illegal_q;
        end
    end

    assign push_data = {err_p1 ? 32'd0 : sram_rdata,
                        err_p1 ? RESP_SLVERR : RESP_OKAY,
                        last_p1};

    axi_rd_fifo #(
        .DATA_W (BUF_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (buf_data),
        .vld       (buf_vld),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed bench for axi_sram_rd_slave: a table of burst requests with
// hand-computed SRAM word addresses, plus sequences for pending AR and
// mid-burst reset.
`timescale 1ns/1ps
module tb_axi_sram_rd_slave;
    import axi_pkg::*;

    localparam int MEM_AW = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        sram_en;
    logic [MEM_AW-3:0] sram_addr;
    logic [31:0] sram_rdata;

    int checks   = 0;
    int failures = 0;

    typedef logic [7:0][11:0] ea_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  rmode;
        logic [1:0]  resp;
        ea_t         ea;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    axi_sram_rd_slave #(.MEM_AW(MEM_AW), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata)
    );

    function automatic logic [31:0] mk_word(input logic [11:0] a);
        return {a, 4'hA, ~a, 4'h5};
    endfunction

    function automatic ea_t ea8(input logic [11:0] a0, a1, a2, a3, a4, a5, a6, a7);
        ea_t e;
        e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
        e[4] = a4; e[5] = a5; e[6] = a6; e[7] = a7;
        return e;
    endfunction

    // SRAM model: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mk_word(sram_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input string tag, input vec_t v);
        int k, beats, first_rv, n_en, guard, issued, popped, occ, max_occ, last_k, n;
        logic [11:0] en_addr [$];
        logic        stall;
        logic        illegal;
        logic [38:0] held;
        logic [38:0] cur;
        n       = int'(v.len) + 1;
        illegal = (v.resp == RESP_SLVERR);
        @(negedge clk);
        arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size;
        arburst = v.burst; arvalid = 1'b1; rready = 1'b0;
        #1;
        guard = 0;
        while (!arready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        check({tag, "_arready"}, 64'(arready), 64'd1);
        k = 0; beats = 0; first_rv = -1; n_en = 0; issued = 0; popped = 0;
        max_occ = 0; last_k = 0; stall = 1'b0; held = '0;
        while (beats < n && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1) arvalid = 1'b0;
            case (v.rmode)
                2'd0:    rready = 1'b1;
                2'd1:    rready = (k % 3 == 1);
                default: rready = (k >= 8);
            endcase
            #1;
            cur = {rid, rdata, rresp, rlast};
            if (stall) begin
                check({tag, "_hold_valid"}, 64'(rvalid), 64'd1);
                check({tag, "_hold_data"}, 64'(cur), 64'(held));
            end
            if (k == 1) check({tag, "_sram_en_T1"}, 64'(sram_en), 64'(!illegal));
            if (sram_en) begin
                en_addr.push_back(sram_addr);
                n_en++;
            end
            occ = issued + int'(sram_en) - popped - int'(rvalid && rready);
            if (occ > max_occ) max_occ = occ;
            issued += int'(sram_en);
            if (rvalid && first_rv < 0) first_rv = k;
            if (rvalid && rready) begin
                check({tag, "_rid"}, 64'(rid), 64'(v.id));
                check({tag, "_rdata"}, 64'(rdata), illegal ? 64'd0 : 64'(mk_word(v.ea[beats])));
                check({tag, "_rresp"}, 64'(rresp), 64'(v.resp));
                check({tag, "_rlast"}, 64'(rlast), 64'(beats == n - 1));
                beats++;
                popped++;
                last_k = k;
            end
            stall = rvalid && !rready;
            held  = cur;
        end
        check({tag, "_beats"}, 64'(beats), 64'(n));
        check({tag, "_first_rvalid"}, 64'(first_rv), 64'd3);
        check({tag, "_sram_reads"}, 64'(n_en), illegal ? 64'd0 : 64'(n));
        if (!illegal) begin
            for (int i = 0; i < n_en && i < 8; i++)
                check({tag, "_sram_addr"}, 64'(en_addr[i]), 64'(v.ea[i]));
        end
        check({tag, "_occ_le2"}, 64'(max_occ <= 2), 64'd1);
        if (v.rmode == 2'd0) check({tag, "_no_bubble"}, 64'(last_k), 64'(n + 2));
        @(negedge clk); #1;
        check({tag, "_idle_arready"}, 64'(arready), 64'd1);
        check({tag, "_idle_rvalid"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, beats, lasts, k, guard;

        vecs[0]  = '{4'd5,  32'h0000_0100, 8'd3, 3'd2, BURST_INCR,  2'd0, RESP_OKAY,
                     ea8(12'h040, 12'h041, 12'h042, 12'h043, 0, 0, 0, 0)};
        vecs[1]  = '{4'd3,  32'h0000_0038, 8'd3, 3'd2, BURST_WRAP,  2'd0, RESP_OKAY,
                     ea8(12'h00E, 12'h00F, 12'h00C, 12'h00D, 0, 0, 0, 0)};
        vecs[2]  = '{4'd9,  32'h0000_0200, 8'd7, 3'd2, BURST_INCR,  2'd1, RESP_OKAY,
                     ea8(12'h080, 12'h081, 12'h082, 12'h083, 12'h084, 12'h085, 12'h086, 12'h087)};
        vecs[3]  = '{4'd6,  32'h0000_0040, 8'd2, 3'd2, 2'd3,        2'd0, RESP_SLVERR,
                     ea8(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{4'd7,  32'h0000_0040, 8'd2, 3'd2, BURST_WRAP,  2'd1, RESP_SLVERR,
                     ea8(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{4'd1,  32'h0000_0044, 8'd2, 3'd2, BURST_FIXED, 2'd0, RESP_OKAY,
                     ea8(12'h011, 12'h011, 12'h011, 0, 0, 0, 0, 0)};
        vecs[6]  = '{4'd2,  32'h0000_0010, 8'd4, 3'd0, BURST_INCR,  2'd0, RESP_OKAY,
                     ea8(12'h004, 12'h004, 12'h004, 12'h004, 12'h005, 0, 0, 0)};
        vecs[7]  = '{4'd8,  32'h0000_000A, 8'd3, 3'd1, BURST_WRAP,  2'd2, RESP_OKAY,
                     ea8(12'h002, 12'h003, 12'h003, 12'h002, 0, 0, 0, 0)};
        vecs[8]  = '{4'hF,  32'h0001_3FFC, 8'd1, 3'd2, BURST_INCR,  2'd0, RESP_OKAY,
                     ea8(12'hFFF, 12'h000, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{4'd4,  32'h0000_0300, 8'd3, 3'd2, BURST_INCR,  2'd2, RESP_OKAY,
                     ea8(12'h0C0, 12'h0C1, 12'h0C2, 12'h0C3, 0, 0, 0, 0)};
        vecs[10] = '{4'hB,  32'h0000_0000, 8'd0, 3'd3, BURST_INCR,  2'd0, RESP_SLVERR,
                     ea8(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{4'hA,  32'h0000_0020, 8'd0, 3'd2, BURST_INCR,  2'd0, RESP_OKAY,
                     ea8(12'h008, 0, 0, 0, 0, 0, 0, 0)};

        rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
        arsize = '0; arburst = '0; rready = 1'b0; sram_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arready",   64'(arready),   64'd0);
        check("rst_rvalid",    64'(rvalid),    64'd0);
        check("rst_rlast",     64'(rlast),     64'd0);
        check("rst_rid",       64'(rid),       64'd0);
        check("rst_rdata",     64'(rdata),     64'd0);
        check("rst_rresp",     64'(rresp),     64'd0);
        check("rst_sram_en",   64'(sram_en),   64'd0);
        check("rst_sram_addr", 64'(sram_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_rst_arready", 64'(arready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i]);
        end

        // Request held during a burst is accepted again once IDLE.
        @(negedge clk);
        arid = 4'd2; araddr = 32'h80; arlen = 8'd1; arsize = 3'd2;
        arburst = BURST_INCR; arvalid = 1'b1; rready = 1'b1;
        hs = 0; beats = 0; lasts = 0; k = 0;
        while (beats < 4 && k < 100) begin
            #1;
            if (arvalid && arready) hs++;
            if (rvalid) begin
                check("pend_rid", 64'(rid), 64'd2);
                check("pend_rdata", 64'(rdata), 64'(mk_word(12'h020 + 12'(beats % 2))));
                if (rlast) lasts++;
                beats++;
            end
            @(negedge clk);
            k++;
            if (hs == 2) arvalid = 1'b0;
        end
        check("pend_handshakes", 64'(hs), 64'd2);
        check("pend_beats", 64'(beats), 64'd4);
        check("pend_rlast_count", 64'(lasts), 64'd2);

        // Reset on beat 2 of a 16-beat burst.
        @(negedge clk);
        arid = 4'hC; araddr = 32'h400; arlen = 8'd15; arsize = 3'd2;
        arburst = BURST_INCR; arvalid = 1'b1; rready = 1'b1;
        #1;
        guard = 0;
        while (!arready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        beats = 0; k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (k == 1) arvalid = 1'b0;
            #1;
            if (rvalid) begin
                if (beats == 1) break;
                beats++;
            end
        end
        check("rstburst_reached_beat2", 64'(beats), 64'd1);
        rst = 1'b1;
        #1;
        check("rstburst_rvalid_now", 64'(rvalid), 64'd0);
        check("rstburst_rlast_now",  64'(rlast),  64'd0);
        @(negedge clk); #1;
        check("rstburst_arready_in_rst", 64'(arready),   64'd0);
        check("rstburst_sram_en_in_rst", 64'(sram_en),   64'd0);
        check("rstburst_rdata_in_rst",   64'(rdata),     64'd0);
        check("rstburst_rid_in_rst",     64'(rid),       64'd0);
        check("rstburst_addr_in_rst",    64'(sram_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstburst_arready_release", 64'(arready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rstburst_no_stale_beat", 64'(rvalid), 64'd0);
        end
        run_burst("after_rst_len0", vecs[11]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
